// File: rtl/rom_stream_fifo.sv
// rom_stream_fifo: credit-based streamer from a synchronous ROM
// into an internal FIFO, with loop, abort and ROM latency options.
module rom_stream_fifo #(
  parameter int DW      = 32,
  parameter int AW      = 7,
  parameter int DEPTH   = 16,
  parameter int ROM_LAT = 1
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_mode,
  input  logic [AW-1:0]            base_addr,
  input  logic [AW:0]              length,
  output logic                     rom_en,
  output logic [AW-1:0]            rom_addr,
  input  logic [DW-1:0]            rom_data,
  input  logic                     rd_en,
  output logic [DW-1:0]            fifo_out,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     done
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      base_q, base_d;
  logic [AW-1:0]      cur_q, cur_d;
  logic [AW:0]        len_q, len_d;
  logic [AW:0]        rem_q, rem_d;
  logic               loop_q, loop_d;
  logic [ROM_LAT-1:0] vld_q, vld_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]      out_q, out_d;
  logic [DW-1:0]      mem_q [DEPTH];

  logic [CW:0] infl;
  logic [CW:0] used;
  logic        issue;
  logic        push;
  logic        pop;

  // Credit counts FIFO entries plus words still travelling through the ROM.
  always_comb begin
    infl = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      infl = infl + (CW+1)'(vld_q[i]);
    end
    used  = {1'b0, cnt_q} + infl;
    issue = (state_q == S_RUN) && !stop
         && (rem_q != '0)
         && (used < (CW+1)'(DEPTH));
    push  = vld_q[ROM_LAT-1];
    pop   = rd_en && (cnt_q != '0);
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cur_d   = cur_q;
    len_d   = len_q;
    rem_d   = rem_q;
    loop_d  = loop_q;
    vld_d[0] = issue;
    for (int i = 1; i < ROM_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          cur_d   = base_addr;
          len_d   = length;
          rem_d   = length;
          loop_d  = loop_mode;
          state_d = (length == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_DRAIN;
        end else if (issue) begin
          cur_d = cur_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == (AW+1)'(1)) begin
            if (loop_q) begin
              cur_d = base_q;
              rem_d = len_q;
            end else begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (infl == '0) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    out_d    = pop ? mem_q[rd_ptr_q] : out_q;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      cur_q    <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      loop_q   <= 1'b0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      cur_q    <= cur_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      loop_q   <= loop_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= rom_data;
  end

  assign rom_en     = issue;
  assign rom_addr   = cur_q;
  assign fifo_out   = out_q;
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(DEPTH));
  assign fifo_count = cnt_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_rom_stream_fifo.sv
// tb_rom_stream_fifo: directed bench for rom_stream_fifo,
// ROM_LAT=1 instance for most cases, ROM_LAT=2 instance for reset.
module tb_rom_stream_fifo;
  localparam int DW = 32;
  localparam int AW = 7;
  localparam int DEPTH = 16;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          rst, start, stop, loop_mode, rd_en;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] fifo_out;
  logic          fifo_empty, fifo_full, busy, done;
  logic [4:0]    fifo_count;

  logic          rst2, start2, stop2, loop2, rd_en2;
  logic [AW-1:0] base2;
  logic [AW:0]   len2;
  logic          rom_en2;
  logic [AW-1:0] rom_addr2;
  logic [DW-1:0] rom_p2, rom_data2;
  logic [DW-1:0] fifo_out2;
  logic          empty2, full2, busy2, done2;
  logic [4:0]    count2;

  rom_stream_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .ROM_LAT(1)) dut (
    .clk_in(clk_in), .rst(rst), .start(start), .stop(stop),
    .loop_mode(loop_mode), .base_addr(base_addr), .length(length),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .rd_en(rd_en), .fifo_out(fifo_out), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_count(fifo_count),
    .busy(busy), .done(done)
  );

  rom_stream_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .ROM_LAT(2)) dut2 (
    .clk_in(clk_in), .rst(rst2), .start(start2), .stop(stop2),
    .loop_mode(loop2), .base_addr(base2), .length(len2),
    .rom_en(rom_en2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .rd_en(rd_en2), .fifo_out(fifo_out2), .fifo_empty(empty2),
    .fifo_full(full2), .fifo_count(count2),
    .busy(busy2), .done(done2)
  );

  // ROM contents: ROM[i] = i
  always @(posedge clk_in) if (rom_en) rom_data <= DW'(rom_addr);
  always @(posedge clk_in) begin
    if (rom_en2) rom_p2 <= DW'(rom_addr2);
    rom_data2 <= rom_p2;
  end

  int n_en = 0, n_done = 0, n_en2 = 0;
  always @(posedge clk_in) begin
    if (rom_en) n_en <= n_en + 1;
    if (done) n_done <= n_done + 1;
    if (rom_en2) n_en2 <= n_en2 + 1;
  end

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l,
                          input logic lp);
    @(negedge clk_in);
    base_addr = b; length = l; loop_mode = lp; start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk_in);
      k++;
    end
    check(tag, 32'(done), 32'd1);
    @(negedge clk_in);
  endtask

  task automatic pop_chk(input string tag, input int exp);
    @(negedge clk_in);
    rd_en = 1'b1;
    @(negedge clk_in);
    rd_en = 1'b0;
    check(tag, fifo_out, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0, d0, en_s, idx, cyc, got_n, maxc, k;
    bit pend, sawfull;
    int wrap_exp [4];
    wrap_exp = '{126, 127, 0, 1};

    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_mode = 1'b0;
    rd_en = 1'b0; base_addr = '0; length = '0;
    rst2 = 1'b1; start2 = 1'b0; stop2 = 1'b0; loop2 = 1'b0;
    rd_en2 = 1'b0; base2 = '0; len2 = '0;
    repeat (2) @(negedge clk_in);

    check("rst_rom_en", 32'(rom_en), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_empty", 32'(fifo_empty), 1);
    check("rst_full", 32'(fifo_full), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_out", fifo_out, 0);
    rst = 1'b0;
    rst2 = 1'b0;

    // T1 basic
    en0 = n_en; d0 = n_done;
    do_start(0, 8, 0);
    check("t1_busy", 32'(busy), 1);
    @(negedge clk_in);
    check("t1_lat_a", 32'(fifo_count), 0);
    @(negedge clk_in);
    check("t1_lat_b", 32'(fifo_count), 1);
    wait_done("t1_done", 40);
    check("t1_idle", 32'(busy), 0);
    check("t1_pulse", 32'(done), 0);
    check("t1_issued", n_en - en0, 8);
    check("t1_ndone", n_done - d0, 1);
    check("t1_count", 32'(fifo_count), 8);
    for (int i = 0; i < 8; i++) pop_chk("t1_data", i);
    check("t1_empty", 32'(fifo_empty), 1);

    // T2 backpressure
    en0 = n_en; d0 = n_done;
    do_start(0, 40, 0);
    cyc = 0; got_n = 0; maxc = 0; pend = 1'b0; sawfull = 1'b0;
    while (got_n < 40 && cyc < 1000) begin
      @(negedge clk_in);
      cyc++;
      if (pend) begin
        check("t2_data", fifo_out, got_n);
        got_n++;
      end
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      if (fifo_full) sawfull = 1'b1;
      pend = (cyc % 4 == 0) && !fifo_empty;
      rd_en = pend;
    end
    rd_en = 1'b0;
    check("t2_words", got_n, 40);
    check("t2_maxcount", maxc, 16);
    check("t2_sawfull", 32'(sawfull), 1);
    check("t2_issued", n_en - en0, 40);
    check("t2_ndone", n_done - d0, 1);
    check("t2_empty", 32'(fifo_empty), 1);

    // T3 address wrap
    do_start(126, 4, 0);
    wait_done("t3_done", 30);
    for (int i = 0; i < 4; i++) pop_chk("t3_data", wrap_exp[i]);
    check("t3_empty", 32'(fifo_empty), 1);

    // T4 loop then stop
    en0 = n_en; d0 = n_done;
    do_start(5, 3, 1);
    idx = 0; pend = 1'b0;
    repeat (30) begin
      @(negedge clk_in);
      if (pend) begin
        check("t4_data", fifo_out, 5 + idx % 3);
        idx++;
      end
      pend = !fifo_empty;
      rd_en = pend;
    end
    @(negedge clk_in);
    if (pend) begin
      check("t4_data", fifo_out, 5 + idx % 3);
      idx++;
    end
    rd_en = 1'b0;
    stop = 1'b1;
    #1;
    check("t4_stop_noen", 32'(rom_en), 0);
    check("t4_stop_busy", 32'(busy), 1);
    @(negedge clk_in);
    stop = 1'b0;
    en_s = n_en;
    wait_done("t4_done", 20);
    check("t4_no_issue", n_en, en_s);
    k = 0;
    while (!fifo_empty && k < 20) begin
      pop_chk("t4_tail", 5 + idx % 3);
      idx++;
      k++;
    end
    check("t4_looped", 32'((n_en - en0) > 3), 1);
    check("t4_all_landed", idx, n_en - en0);
    check("t4_ndone", n_done - d0, 1);

    // T5 edge cases
    en0 = n_en; d0 = n_done;
    do_start(0, 0, 0);
    check("t5_len0_done", 32'(done), 1);
    @(negedge clk_in);
    check("t5_len0_pulse", 32'(done), 0);
    check("t5_len0_idle", 32'(busy), 0);
    check("t5_len0_noen", n_en, en0);
    do_start(0, 8, 0);
    @(negedge clk_in);
    base_addr = 100; length = 3; loop_mode = 1'b1; start = 1'b1;
    @(negedge clk_in);
    start = 1'b0; loop_mode = 1'b0;
    wait_done("t5_done", 40);
    check("t5_issued", n_en - en0, 8);
    check("t5_ndone", n_done - d0, 2);
    for (int i = 0; i < 8; i++) pop_chk("t5_data", i);
    @(negedge clk_in);
    rd_en = 1'b1;
    @(negedge clk_in);
    rd_en = 1'b0;
    check("t5_empty_pop_out", fifo_out, 7);
    check("t5_empty_pop_cnt", 32'(fifo_count), 0);

    // T6 reset mid-run, ROM_LAT=2
    @(negedge clk_in);
    base2 = 10; len2 = 20; start2 = 1'b1;
    @(negedge clk_in);
    start2 = 1'b0;
    repeat (6) @(negedge clk_in);
    check("t6_running", 32'(busy2), 1);
    check("t6_filled", 32'(count2 != '0), 1);
    rst2 = 1'b1;
    #1;
    check("t6_rst_en", 32'(rom_en2), 0);
    check("t6_rst_addr", 32'(rom_addr2), 0);
    check("t6_rst_busy", 32'(busy2), 0);
    check("t6_rst_done", 32'(done2), 0);
    check("t6_rst_empty", 32'(empty2), 1);
    check("t6_rst_full", 32'(full2), 0);
    check("t6_rst_count", 32'(count2), 0);
    check("t6_rst_out", fifo_out2, 0);
    @(negedge clk_in);
    rst2 = 1'b0;
    en0 = n_en2;
    @(negedge clk_in);
    base2 = 120; len2 = 10; start2 = 1'b1;
    @(negedge clk_in);
    start2 = 1'b0;
    check("t6_lat_a", 32'(count2), 0);
    @(negedge clk_in);
    check("t6_lat_b", 32'(count2), 0);
    @(negedge clk_in);
    check("t6_lat_c", 32'(count2), 0);
    @(negedge clk_in);
    check("t6_lat_d", 32'(count2), 1);
    k = 0;
    while (!done2 && k < 40) begin
      @(negedge clk_in);
      k++;
    end
    check("t6_done", 32'(done2), 1);
    check("t6_issued", n_en2 - en0, 10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      rd_en2 = 1'b1;
      @(negedge clk_in);
      rd_en2 = 1'b0;
      check("t6_data", fifo_out2, (120 + i) % 128);
    end
    check("t6_empty", 32'(empty2), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
